axi_rd_arb: RTL and testbench

Four-requester AXI read-address arbiter and read-response router sharing a single 256-bit AXI read master port. Requesters present AR requests tagged with a 5-bit local tag. The block grants them round-robin into a registered AR output stage and encodes the requester index into `arid[6:5]`. It then steers R beats back to the owning requester by `rid[6:5]`. It sits between the engine-side read clients and the AXI read master interface.

---
 rtl/axi_rd_arb_if.sv | 45 ++++
 rtl/axi_rd_arb.sv | 99 +++++++++
 tb/tb_axi_rd_arb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_if.sv
// Bundle for the arbiter: four requester AR/R lanes plus the shared AXI read port.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface axi_rd_arb_if;
    logic [3:0]   req_arvalid;
    logic [127:0] req_araddr;
    logic [31:0]  req_arlen;
    logic [19:0]  req_artag;
    logic [3:0]   req_arready;
    logic [3:0]   req_rvalid;
    logic [255:0] req_rdata;
    logic [1:0]   req_rresp;
    logic         req_rlast;
    logic [4:0]   req_rtag;
    logic [3:0]   req_rready;

    logic [6:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [6:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_artag, req_rready,
        output req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
        output req_rtag,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_artag, req_rready,
        input  req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
        input  req_rtag,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arb.sv
// Four-way round-robin AXI read arbiter with rid-based R steering.
// Define AXI_RD_ARB_OUTS_LIMIT_EN to build per-requester outstanding limits.
module axi_rd_arb #(
    parameter int MAX_OUTS = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    axi_rd_arb_if.master bus
);
    logic       load;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic [1:0] rr_ptr;
    logic [1:0] rsel;
    logic [3:0] full;
    logic [3:0] eligible;
    logic [3:0] grant;

    assign load     = !bus.arvalid | bus.arready;
    assign eligible = bus.req_arvalid & ~full;

    // first eligible requester starting at rr_ptr, wrapping mod 4
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant           = (load && found) ? (4'b0001 << win) : 4'b0000;
    assign bus.req_arready = grant;
    assign bus.arsize      = 3'b101;
    assign bus.arburst     = 2'b01;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus.arvalid <= 1'b0;
            bus.arid    <= 7'd0;
            bus.araddr  <= 32'd0;
            bus.arlen   <= 8'd0;
            rr_ptr      <= 2'd0;
        end else if (load) begin
            bus.arvalid <= found;
            if (found) begin
                bus.arid   <= {win, bus.req_artag[5*win +: 5]};
                bus.araddr <= bus.req_araddr[32*win +: 32];
                bus.arlen  <= bus.req_arlen[8*win +: 8];
                rr_ptr     <= win + 2'd1;
            end
        end
    end

`ifdef AXI_RD_ARB_OUTS_LIMIT_EN
    logic [3:0] outs_cnt [4];
    logic [3:0] done_vec;
    logic       r_done;

    assign r_done   = bus.rvalid & bus.rready & bus.rlast;
    assign done_vec = r_done ? (4'b0001 << rsel) : 4'b0000;

    always_comb begin
        full = 4'b0000;
        for (int i = 0; i < 4; i++)
            full[i] = (outs_cnt[i] == 4'(MAX_OUTS));
    end

    // a stray completion at zero is routed but leaves the count at zero
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++)
                outs_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i] && !done_vec[i])
                    outs_cnt[i] <= outs_cnt[i] + 4'd1;
                else if (!grant[i] && done_vec[i] && outs_cnt[i] != 4'd0)
                    outs_cnt[i] <= outs_cnt[i] - 4'd1;
            end
        end
    end
`else
    assign full = 4'b0000;
`endif

    assign rsel           = bus.rid[6:5];
    assign bus.rready     = bus.req_rready[rsel];
    assign bus.req_rvalid = bus.rvalid ? (4'b0001 << rsel) : 4'b0000;
    assign bus.req_rdata  = bus.rdata;
    assign bus.req_rresp  = bus.rresp;
    assign bus.req_rlast  = bus.rlast;
    assign bus.req_rtag   = bus.rid[4:0];
endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: AR arbitration, hold, R routing, limits, reset.
module tb_axi_rd_arb;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef AXI_RD_ARB_OUTS_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    axi_rd_arb_if bus ();

    axi_rd_arb #(.MAX_OUTS(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       ardy;
        logic [3:0] exp_grant;
        logic       exp_av;
        logic [6:0] exp_id;
    } ar_vec_t;

    typedef struct {
        logic [6:0] rid;
        logic       rvalid;
        logic [3:0] rrdy;
        logic       exp_rready;
        logic [3:0] exp_rvalid;
        logic [4:0] exp_tag;
    } r_vec_t;

    ar_vec_t ar_tab [7];
    r_vec_t  r_tab  [5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_arvalid = 4'b0000;
        bus.arready     = 1'b0;
        bus.rvalid      = 1'b0;
        bus.rlast       = 1'b0;
        bus.rid         = 7'd0;
        bus.req_rready  = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic set_reqs();
        bus.req_araddr = {32'h400, 32'h300, 32'h200, 32'h100};
        bus.req_arlen  = {8'd3, 8'd2, 8'd1, 8'd0};
        bus.req_artag  = {5'd4, 5'd3, 5'd2, 5'd1};
    endtask

    initial begin
        logic [3:0] lim_g;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        set_reqs();
        bus.rdata = '0;
        bus.rresp = 2'b00;

        ar_tab[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 7'h00};
        ar_tab[1] = '{4'hF, 1'b1, 4'b0010, 1'b1, 7'h01};
        ar_tab[2] = '{4'hF, 1'b1, 4'b0100, 1'b1, 7'h22};
        ar_tab[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 7'h43};
        ar_tab[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 7'h64};
        ar_tab[5] = '{4'h0, 1'b1, 4'b0000, 1'b1, 7'h01};
        ar_tab[6] = '{4'h0, 1'b1, 4'b0000, 1'b0, 7'h00};

        r_tab[0] = '{7'h2C, 1'b1, 4'b0100, 1'b0, 4'b0010, 5'h0C};
        r_tab[1] = '{7'h4A, 1'b1, 4'b0100, 1'b1, 4'b0100, 5'h0A};
        r_tab[2] = '{7'h4A, 1'b0, 4'b0100, 1'b1, 4'b0000, 5'h0A};
        r_tab[3] = '{7'h7F, 1'b1, 4'b1000, 1'b1, 4'b1000, 5'h1F};
        r_tab[4] = '{7'h00, 1'b1, 4'b1110, 1'b0, 4'b0001, 5'h00};

        #3;
        chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst_arid", 64'(bus.arid), 64'd0);
        chk("rst_araddr", 64'(bus.araddr), 64'd0);
        chk("rst_arlen", 64'(bus.arlen), 64'd0);
        chk("rst_arsize", 64'(bus.arsize), 64'd5);
        chk("rst_arburst", 64'(bus.arburst), 64'd1);
        chk("rst_req_arready", 64'(bus.req_arready), 64'd0);
        #4;
        rst = 1'b0;

        // round-robin with everyone requesting
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.req_arvalid = ar_tab[i].rv;
            bus.arready     = ar_tab[i].ardy;
            #3;
            chk($sformatf("rr_grant[%0d]", i), 64'(bus.req_arready),
                64'(ar_tab[i].exp_grant));
            chk($sformatf("rr_arvalid[%0d]", i), 64'(bus.arvalid),
                64'(ar_tab[i].exp_av));
            if (ar_tab[i].exp_av) begin
                chk($sformatf("rr_arid[%0d]", i), 64'(bus.arid),
                    64'(ar_tab[i].exp_id));
                chk($sformatf("rr_araddr[%0d]", i), 64'(bus.araddr),
                    64'(32'h100 * (ar_tab[i].exp_id[6:5] + 1)));
            end
        end

        // requester 2 held under AR backpressure
        do_reset();
        bus.req_artag[14:10]  = 5'h0A;
        bus.req_araddr[95:64] = 32'h1000;
        bus.req_arlen[23:16]  = 8'd3;
        tick();
        bus.req_arvalid = 4'b0100;
        bus.arready     = 1'b0;
        #3;
        chk("hold_grant0", 64'(bus.req_arready), 64'b0100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #3;
            chk($sformatf("hold_rdy[%0d]", i), 64'(bus.req_arready), 64'd0);
            chk($sformatf("hold_av[%0d]", i), 64'(bus.arvalid), 64'd1);
            chk($sformatf("hold_id[%0d]", i), 64'(bus.arid), 64'h4A);
            chk($sformatf("hold_addr[%0d]", i), 64'(bus.araddr), 64'h1000);
            chk($sformatf("hold_len[%0d]", i), 64'(bus.arlen), 64'd3);
        end
        tick();
        bus.arready = 1'b1;
        #3;
        chk("hold_release", 64'(bus.req_arready), 64'b0100);
        set_reqs();

        // R routing, combinational
        do_reset();
        bus.rdata = {8{32'hDEADBEEF}};
        bus.rresp = 2'b10;
        bus.rlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.rid        = r_tab[i].rid;
            bus.rvalid     = r_tab[i].rvalid;
            bus.req_rready = r_tab[i].rrdy;
            #3;
            chk($sformatf("r_rready[%0d]", i), 64'(bus.rready),
                64'(r_tab[i].exp_rready));
            chk($sformatf("r_rvalid[%0d]", i), 64'(bus.req_rvalid),
                64'(r_tab[i].exp_rvalid));
            chk($sformatf("r_rtag[%0d]", i), 64'(bus.req_rtag),
                64'(r_tab[i].exp_tag));
        end
        chk("r_rdata", 64'(bus.req_rdata[255:192]), 64'hDEADBEEF_DEADBEEF);
        chk("r_rresp", 64'(bus.req_rresp), 64'd2);
        chk("r_rlast", 64'(bus.req_rlast), 64'd1);

        // outstanding limit for requester 1
        do_reset();
        lim_g = LIM ? 4'b0000 : 4'b0010;
        tick();
        bus.req_arvalid = 4'b0010;
        bus.arready     = 1'b1;
        #3;
        chk("lim_g0", 64'(bus.req_arready), 64'b0010);
        tick();
        #3;
        chk("lim_g1", 64'(bus.req_arready), 64'b0010);
        tick();
        #3;
        chk("lim_g2", 64'(bus.req_arready), 64'(lim_g));
        tick();
        #3;
        chk("lim_g3", 64'(bus.req_arready), 64'(lim_g));
        tick();
        bus.rid        = 7'h25;
        bus.rvalid     = 1'b1;
        bus.rlast      = 1'b1;
        bus.req_rready = 4'b0010;
        #3;
        chk("lim_rready", 64'(bus.rready), 64'd1);
        chk("lim_g4", 64'(bus.req_arready), 64'(lim_g));
        tick();
        bus.rvalid = 1'b0;
        #3;
        chk("lim_g5", 64'(bus.req_arready), 64'b0010);

        // grant and completion in the same cycle for requester 0
        do_reset();
        tick();
        bus.req_arvalid = 4'b0001;
        bus.arready     = 1'b1;
        #3;
        chk("sim_g0", 64'(bus.req_arready), 64'b0001);
        tick();
        bus.rid        = 7'h00;
        bus.rvalid     = 1'b1;
        bus.rlast      = 1'b1;
        bus.req_rready = 4'b0001;
        #3;
        chk("sim_g1", 64'(bus.req_arready), 64'b0001);
        tick();
        bus.rvalid = 1'b0;
        #3;
        chk("sim_g2", 64'(bus.req_arready), 64'b0001);
        tick();
        #3;
        chk("sim_g3", 64'(bus.req_arready), LIM ? 64'd0 : 64'b0001);
        chk("pre_rst_av", 64'(bus.arvalid), 64'd1);

        // asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        chk("arst_av", 64'(bus.arvalid), 64'd0);
        chk("arst_id", 64'(bus.arid), 64'd0);
        bus.req_arvalid = 4'b0000;
        #1;
        rst = 1'b0;
        tick();
        bus.req_arvalid = 4'hF;
        bus.arready     = 1'b1;
        #3;
        chk("arst_g0", 64'(bus.req_arready), 64'b0001);
        tick();
        #3;
        chk("arst_g1", 64'(bus.req_arready), 64'b0010);
        chk("arst_id1", 64'(bus.arid), 64'h01);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
